// File: rtl/emulib_pkt_fifo.sv
// Packet FIFO: store-and-forward (commit on last beat, drop on abort or overflow)
// or cut-through; zero-latency output from the storage array.
module emulib_pkt_fifo #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned PKT_MODE = 1,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 1,
    parameter int unsigned CNTW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ivalid,
    output logic             iready,
    input  logic [WIDTH-1:0] idata,
    input  logic             ilast,
    input  logic             iabort,
    output logic             ovalid,
    input  logic             oready,
    output logic [WIDTH-1:0] odata,
    output logic             olast,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNTW-1:0]  item_cnt,
    output logic [CNTW-1:0]  burst_cnt,
    output logic [15:0]      drop_cnt
);
    localparam int unsigned     PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_DEPTH = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] AF_CNT    = CNTW'(AF_LEVEL);
    localparam logic [CNTW-1:0] AE_CNT    = CNTW'(AE_LEVEL);

    typedef enum logic {PASS, DROP} state_t;

    logic [WIDTH:0]  mem [DEPTH];
    logic [PW-1:0]   wp, cp, rp, wp_d, cp_d, rp_d;
    logic [CNTW-1:0] occ, occ_d, item_d, burst_d;
    logic [15:0]     drop_d;
    state_t          state, state_d;
    logic            acc, rd, we;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Output side sees only committed entries; item_cnt disambiguates rp == cp
    assign ovalid       = (rp != cp) || (item_cnt == CNT_DEPTH);
    assign {odata, olast} = mem[rp];
    assign iready       = ((PKT_MODE != 0) && (state == DROP)) || (occ != CNT_DEPTH);
    assign acc          = ivalid && iready;
    assign rd           = ovalid && oready;
    assign full         = !iready;
    assign empty        = !ovalid;
    assign almost_full  = (occ >= AF_CNT);
    assign almost_empty = (item_cnt <= AE_CNT);

    // Next-state: read applied first so write/commit/rewind see the net occupancy
    always_comb begin
        wp_d    = wp;
        cp_d    = cp;
        rp_d    = rp;
        occ_d   = occ;
        item_d  = item_cnt;
        burst_d = burst_cnt;
        drop_d  = drop_cnt;
        state_d = state;
        we      = 1'b0;
        if (rd) begin
            rp_d   = ptr_inc(rp);
            occ_d  = occ - CNT_ONE;
            item_d = item_cnt - CNT_ONE;
            if (olast) begin
                burst_d = burst_cnt - CNT_ONE;
            end
        end
        if (acc) begin
            if (PKT_MODE == 0) begin
                we     = 1'b1;
                wp_d   = ptr_inc(wp);
                cp_d   = ptr_inc(wp);
                occ_d  = occ_d + CNT_ONE;
                item_d = occ_d;
                if (ilast) begin
                    burst_d = burst_d + CNT_ONE;
                end
            end else if (state == DROP) begin
                if (ilast) begin
                    state_d = PASS;
                    drop_d  = sat_inc(drop_cnt);
                end
            end else if (ilast && iabort) begin
                wp_d   = cp;
                occ_d  = item_d;
                drop_d = sat_inc(drop_cnt);
            end else if (ilast) begin
                we      = 1'b1;
                wp_d    = ptr_inc(wp);
                cp_d    = ptr_inc(wp);
                occ_d   = occ_d + CNT_ONE;
                item_d  = occ_d;
                burst_d = burst_d + CNT_ONE;
            end else if (occ_d + CNT_ONE == CNT_DEPTH) begin
                // Packet cannot fit: throw away its partial beats and swallow the rest
                state_d = DROP;
                wp_d    = cp;
                occ_d   = item_d;
            end else begin
                we    = 1'b1;
                wp_d  = ptr_inc(wp);
                occ_d = occ_d + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp        <= '0;
            cp        <= '0;
            rp        <= '0;
            occ       <= '0;
            item_cnt  <= '0;
            burst_cnt <= '0;
            drop_cnt  <= '0;
            state     <= PASS;
        end else begin
            wp        <= wp_d;
            cp        <= cp_d;
            rp        <= rp_d;
            occ       <= occ_d;
            item_cnt  <= item_d;
            burst_cnt <= burst_d;
            drop_cnt  <= drop_d;
            state     <= state_d;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[wp] <= {idata, ilast};
        end
    end
endmodule

// File: tb/tb_emulib_pkt_fifo.sv
// Three FIFO configurations driven by directed and random packets, checked against
// a packet-level queue model and an output scoreboard.
module tb_emulib_pkt_fifo;
    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;
    logic [2:0] iv, il, ia, ordy, ir, ov, ol, fu, em, af, ae;
    logic [2:0][W-1:0] idat, od;
    logic [2:0][15:0] dc;
    logic [2:0][7:0] icw, bcw;
    logic [4:0] ic0, bc0;
    logic [3:0] ic1, bc1;
    logic [2:0] ic2, bc2;

    assign icw[0] = 8'(ic0);
    assign icw[1] = 8'(ic1);
    assign icw[2] = 8'(ic2);
    assign bcw[0] = 8'(bc0);
    assign bcw[1] = 8'(bc1);
    assign bcw[2] = 8'(bc2);

    emulib_pkt_fifo #(.WIDTH(W), .DEPTH(16), .PKT_MODE(1)) u_sf16 (
        .clk(clk), .rst_n(rst_n), .ivalid(iv[0]), .iready(ir[0]), .idata(idat[0]),
        .ilast(il[0]), .iabort(ia[0]), .ovalid(ov[0]), .oready(ordy[0]), .odata(od[0]),
        .olast(ol[0]), .full(fu[0]), .empty(em[0]), .almost_full(af[0]),
        .almost_empty(ae[0]), .item_cnt(ic0), .burst_cnt(bc0), .drop_cnt(dc[0]));

    emulib_pkt_fifo #(.WIDTH(W), .DEPTH(8), .PKT_MODE(1)) u_sf8 (
        .clk(clk), .rst_n(rst_n), .ivalid(iv[1]), .iready(ir[1]), .idata(idat[1]),
        .ilast(il[1]), .iabort(ia[1]), .ovalid(ov[1]), .oready(ordy[1]), .odata(od[1]),
        .olast(ol[1]), .full(fu[1]), .empty(em[1]), .almost_full(af[1]),
        .almost_empty(ae[1]), .item_cnt(ic1), .burst_cnt(bc1), .drop_cnt(dc[1]));

    emulib_pkt_fifo #(.WIDTH(W), .DEPTH(5), .PKT_MODE(0)) u_ct5 (
        .clk(clk), .rst_n(rst_n), .ivalid(iv[2]), .iready(ir[2]), .idata(idat[2]),
        .ilast(il[2]), .iabort(ia[2]), .ovalid(ov[2]), .oready(ordy[2]), .odata(od[2]),
        .olast(ol[2]), .full(fu[2]), .empty(em[2]), .almost_full(af[2]),
        .almost_empty(ae[2]), .item_cnt(ic2), .burst_cnt(bc2), .drop_cnt(dc[2]));

    // Reference state: committed-unread beats, beats of the open packet, output expectations
    logic [W:0] mq   [3][$];
    logic [W:0] pend [3][$];
    logic [W:0] sb   [3][$];
    bit         dropping [3];
    int         drops    [3];
    bit         acc_flag [3];
    int         rmode    [3];
    bit         saw_full;
    int         n_chk;
    int         n_pass;
    logic [W:0] held [3];
    bit         hold [3];

    function automatic int depth_of(input int k);
        case (k)
            0:       return 16;
            1:       return 8;
            default: return 5;
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, k, $time, got, exp);
    endtask

    task automatic bump_drop(input int k);
        drops[k] = (drops[k] == 65535) ? 65535 : drops[k] + 1;
    endtask

    // Compare the DUT against the model, then advance the model by the upcoming edge
    task automatic model_step(input int k);
        int  d, cu, occ, nb;
        bit  pm, er;
        logic [W:0] beat;
        d   = depth_of(k);
        pm  = (k != 2);
        cu  = mq[k].size();
        occ = cu + pend[k].size();
        er  = pm ? (dropping[k] || occ != d) : (cu != d);
        nb  = 0;
        for (int i = 0; i < mq[k].size(); i++) if (mq[k][i][0]) nb++;
        chk("iready", k, 64'(ir[k]), 64'(er));
        chk("ovalid", k, 64'(ov[k]), 64'(cu != 0));
        chk("item_cnt", k, 64'(icw[k]), 64'(cu));
        chk("burst_cnt", k, 64'(bcw[k]), 64'(nb));
        chk("drop_cnt", k, 64'(dc[k]), 64'(drops[k]));
        chk("full", k, 64'(fu[k]), 64'(!er));
        chk("empty", k, 64'(em[k]), 64'(cu == 0));
        chk("almost_full", k, 64'(af[k]), 64'(occ >= d - 2));
        chk("almost_empty", k, 64'(ae[k]), 64'(cu <= 1));
        if (k == 2 && cu == d) saw_full = 1'b1;
        acc_flag[k] = iv[k] && er;
        if (cu != 0 && ordy[k]) void'(mq[k].pop_front());
        if (acc_flag[k]) begin
            beat = {idat[k], il[k]};
            if (!pm) begin
                mq[k].push_back(beat);
                sb[k].push_back(beat);
            end else if (dropping[k]) begin
                if (il[k]) begin
                    dropping[k] = 1'b0;
                    bump_drop(k);
                end
            end else if (il[k] && ia[k]) begin
                pend[k].delete();
                bump_drop(k);
            end else if (il[k]) begin
                pend[k].push_back(beat);
                while (pend[k].size() != 0) begin
                    beat = pend[k].pop_front();
                    mq[k].push_back(beat);
                    sb[k].push_back(beat);
                end
            end else if (mq[k].size() + pend[k].size() + 1 == d) begin
                dropping[k] = 1'b1;
                pend[k].delete();
            end else begin
                pend[k].push_back(beat);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            case (rmode[k])
                0:       ordy[k] = 1'b0;
                1:       ordy[k] = 1'b1;
                2:       ordy[k] = 1'($urandom_range(0, 1));
                default: ordy[k] = ~ordy[k];
            endcase
        end
    endtask

    task automatic send_beat(input int k, input logic [W-1:0] d, input bit last, input bit abort);
        bit done;
        done = 1'b0;
        iv[k] = 1'b1; idat[k] = d; il[k] = last; ia[k] = abort;
        for (int t = 0; t < 300 && !done; t++) begin
            tick();
            done = acc_flag[k];
        end
        iv[k] = 1'b0;
        chk("accept_within_bound", k, 64'(done), 64'd1);
    endtask

    task automatic send_pkt(input int k, input int n, input bit abort, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) tick();
            send_beat(k, $urandom, i == n - 1, (i == n - 1) ? abort : 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic drain(input int k);
        int t;
        t = 0;
        rmode[k] = 1;
        ordy[k] = 1'b1;
        while ((mq[k].size() != 0 || sb[k].size() != 0) && t < 400) begin
            tick();
            t++;
        end
        tick();
        tick();
        chk("drained_within_bound", k, 64'(sb[k].size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        iv = '0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            mq[k].delete(); pend[k].delete(); sb[k].delete();
            dropping[k] = 1'b0; drops[k] = 0;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog timeout");
    end

    // Output monitor: scoreboard compare on every handshake plus hold-stability
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    hold[k] = 1'b0;
                end else begin
                    if (hold[k]) begin
                        chk("ovalid_held", k, 64'(ov[k]), 64'd1);
                        if (ov[k]) chk("data_held", k, 64'({od[k], ol[k]}), 64'(held[k]));
                    end
                    if (ov[k] && ordy[k]) begin
                        if (sb[k].size() == 0) begin
                            n_chk++;
                            $display("FAIL out_beat inst%0d t=%0t: got %0h expected no beat", k, $time, {od[k], ol[k]});
                        end else begin
                            chk("out_beat", k, 64'({od[k], ol[k]}), 64'(sb[k].pop_front()));
                        end
                    end
                    hold[k] = ov[k] && !ordy[k];
                    held[k] = {od[k], ol[k]};
                end
            end
        end
    end

    initial begin
        int n;
        bit ab;
        n_chk = 0; n_pass = 0; saw_full = 1'b0;
        rst_n = 1'b0; iv = '0; il = '0; ia = '0; ordy = '0; idat = '0;
        for (int k = 0; k < 3; k++) begin
            rmode[k] = 0; dropping[k] = 1'b0; drops[k] = 0; acc_flag[k] = 1'b0; hold[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(); tick();

        // Store-and-forward gating with a 4-beat packet
        rmode[0] = 1; ordy[0] = 1'b1;
        send_pkt(0, 4, 1'b0, 1'b0);
        drain(0);

        // Aborted packet followed by a good one
        rmode[0] = 0; ordy[0] = 1'b0;
        send_pkt(0, 3, 1'b1, 1'b0);
        send_pkt(0, 2, 1'b0, 1'b0);
        tick();
        chk("item_peak", 0, 64'(icw[0]), 64'd2);
        drain(0);

        // Oversize packet into DEPTH=8, then a normal packet
        rmode[1] = 0; ordy[1] = 1'b0;
        send_pkt(1, 10, 1'b0, 1'b0);
        send_pkt(1, 2, 1'b0, 1'b0);
        drain(1);

        // Write, commit and read together at occ = DEPTH-1
        rmode[0] = 0; ordy[0] = 1'b0;
        for (int i = 0; i < 15; i++) send_pkt(0, 1, 1'b0, 1'b0);
        rmode[0] = 1; ordy[0] = 1'b1;
        send_pkt(0, 1, 1'b0, 1'b0);
        drain(0);

        // Cut-through with toggling oready across pointer wrap
        rmode[2] = 3; ordy[2] = 1'b0;
        for (int i = 0; i < 12; i++) send_beat(2, $urandom, 1'($urandom_range(0, 2) == 0), 1'b0);
        drain(2);

        // Random packets, aborts, gaps and backpressure on every configuration
        for (int k = 0; k < 3; k++) begin
            rmode[k] = 2;
            for (int p = 0; p < 30; p++) begin
                n  = 1 + int'($urandom_range(0, 32'(depth_of(k) + 2)));
                ab = ($urandom_range(0, 5) == 0);
                send_pkt(k, n, ab, 1'b1);
            end
            drain(k);
        end

        // Reset with stored data and half a packet in flight
        rmode[0] = 0; ordy[0] = 1'b0;
        send_pkt(0, 1, 1'b0, 1'b0);
        send_beat(0, $urandom, 1'b0, 1'b0);
        send_beat(0, $urandom, 1'b0, 1'b0);
        do_reset();
        tick();
        chk("post_reset_empty", 0, 64'(em[0]), 64'd1);
        send_pkt(0, 4, 1'b0, 1'b0);
        drain(0);

        chk("ct_full_seen", 2, 64'(saw_full), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
